note_detector: RTL and testbench

Receive-side counterpart of the piano tone generators. It measures the period of an incoming square-wave tone, clocked by the 100 MHz system clock, and classifies it as one of the seven fifth-octave notes Do..Si. It reports a stable note code plus the raw period, so that played tones can be looped back and checked, or fed to the display/score logic.

---
 rtl/note_detector.sv | 211 +++++++++++++++++++++
 tb/tb_note_detector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_detector.sv
// note_detector
//   Measures the period of an incoming square-wave tone in clk cycles and
//   classifies it as one of the seven fifth-octave notes (0=Do .. 6=Si).
//   Classes are reported only after STABLE_COUNT consecutive agreeing samples.
//
// Parameters
//   TOL           classification window, +/- cycles around each nominal period
//   STABLE_COUNT  agreeing samples before note_valid asserts (1..7)
//   TIMEOUT       idle cycles after which the input is declared silent
//                 (must be < 2**CNT_W)
//   CNT_W         width of the period counter and of period
//   NOM_DIV       divides every nominal period; 1 for the real 100 MHz tone set,
//                 larger values give a proportionally faster note table
//
// Ports
//   clk         system clock (100 MHz)
//   rst         asynchronous, active-high reset
//   tone_in     asynchronous square-wave tone
//   note        stable note code, 0=Do .. 6=Si
//   note_valid  note is stable and current
//   period      last measured period in clk cycles
//   sample_stb  one-cycle pulse per completed measurement
//
// Build option
//   NOTE_DET_GLITCH_FILTER_EN  adds a 3-sample stability filter after the
//                              synchronizer; pulses of 2 cycles or fewer are
//                              ignored and edge-to-strobe latency becomes 6 clk.
module note_detector #(
  parameter int unsigned TOL          = 2000,
  parameter int unsigned STABLE_COUNT = 2,
  parameter int unsigned TIMEOUT      = 250000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned NOM_DIV      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic [CNT_W-1:0] period,
  output logic             sample_stb
);

  localparam logic [31:0] NOM [7] = '{
    32'(191113 / NOM_DIV), 32'(170263 / NOM_DIV), 32'(151686 / NOM_DIV),
    32'(143172 / NOM_DIV), 32'(127553 / NOM_DIV), 32'(113636 / NOM_DIV),
    32'(101238 / NOM_DIV)
  };
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [2:0]       StableCnt  = 3'(STABLE_COUNT);
  localparam logic [2:0]       OutOfBand  = 3'd7;

  typedef enum logic {StIdle, StMeasure} state_e;

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchronizer, optional glitch filter, rising-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], tone_in};
  end

`ifdef NOTE_DET_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic       filt_q, filt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 3'b000;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      filt_q <= filt_d;
    end
  end

  // Level moves only once three consecutive synchronized samples agree.
  always_comb begin
    filt_d = filt_q;
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
  end

  // Edge taken from the next filtered level so the filter adds 3 clk, not 4.
  assign rise = filt_d & ~filt_q;
`else
  logic sync_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_dly_q <= 1'b0;
    else     sync_dly_q <= sync_q[1];
  end

  assign rise = sync_q[1] & ~sync_dly_q;
`endif

  // ---------------------------------------------------------------------------
  // Classification of the period that is about to be reported (cnt_q)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cls;

  function automatic logic in_window(logic [31:0] p, logic [31:0] nom);
    logic [31:0] diff;
    diff = (p > nom) ? (p - nom) : (nom - p);
    return (diff <= TOL);
  endfunction

  // Descending scan so the lowest matching class wins on overlap.
  always_comb begin
    cls = OutOfBand;
    for (int k = 6; k >= 0; k--) begin
      if (in_window(32'(cnt_q), NOM[k])) cls = 3'(k);
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM and stability filter
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_d;
  logic             stb_d;
  logic [2:0]       note_d;
  logic             valid_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       mcnt_q, mcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period     <= '0;
      sample_stb <= 1'b0;
      note       <= 3'd0;
      note_valid <= 1'b0;
      cand_q     <= OutOfBand;
      mcnt_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period     <= period_d;
      sample_stb <= stb_d;
      note       <= note_d;
      note_valid <= valid_d;
      cand_q     <= cand_d;
      mcnt_q     <= mcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period;
    stb_d    = 1'b0;
    note_d   = note;
    valid_d  = note_valid;
    cand_d   = cand_q;
    mcnt_d   = mcnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // First edge only arms; the counter starts at 1 so that the next
        // edge P cycles later reads exactly P.
        if (rise) begin
          state_d = StMeasure;
          cnt_d   = CNT_W'(1);
        end
      end

      StMeasure: begin
        if (rise) begin
          // An edge on the timeout cycle still counts as a sample.
          stb_d    = 1'b1;
          period_d = cnt_q;
          cnt_d    = CNT_W'(1);
          if (cls == cand_q) begin
            mcnt_d = (mcnt_q < StableCnt) ? (mcnt_q + 3'd1) : mcnt_q;
            if ((mcnt_d == StableCnt) && (cand_q != OutOfBand)) begin
              note_d  = cand_q;
              valid_d = 1'b1;
            end
          end else begin
            cand_d  = cls;
            mcnt_d  = 3'd1;
            valid_d = 1'b0;
            if ((StableCnt == 3'd1) && (cls != OutOfBand)) begin
              note_d  = cls;
              valid_d = 1'b1;
            end
          end
        end else if (cnt_q == TimeoutCnt) begin
          // Silence: drop validity but keep note and period for display.
          state_d = StIdle;
          cnt_d   = '0;
          valid_d = 1'b0;
          cand_d  = OutOfBand;
          mcnt_d  = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_note_detector.sv
// Testbench for note_detector with a scaled note table (NOM_DIV=128) so that
// whole tones fit a short run. A timestamp-based reference model predicts the
// strobe, period, note and note_valid for every clock cycle.
module tb_note_detector;

  localparam int unsigned TOL = 20;
  localparam int unsigned SC  = 2;
  localparam int unsigned TO  = 2000;
  localparam int unsigned CW  = 11;
  localparam int unsigned DIV = 128;
`ifdef NOTE_DET_GLITCH_FILTER_EN
  localparam int LAT  = 6;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tone_in;
  logic [2:0]    note;
  logic          note_valid;
  logic [CW-1:0] period;
  logic          sample_stb;

  always #5 clk = ~clk;

  note_detector #(
    .TOL          (TOL),
    .STABLE_COUNT (SC),
    .TIMEOUT      (TO),
    .CNT_W        (CW),
    .NOM_DIV      (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .note       (note),
    .note_valid (note_valid),
    .period     (period),
    .sample_stb (sample_stb)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nom [7];

  // Reference model: rise timestamps in, per-cycle expected outputs out.
  int   due_q [$];
  int   hist  [$];
  bit   armed;
  int   last_e;
  int   m_note, m_valid, m_period, m_stb;
  logic prev_lvl;

  function automatic int classify(int p);
    for (int k = 0; k < 7; k++) begin
      if (((p > nom[k]) ? (p - nom[k]) : (nom[k] - p)) <= TOL) return k;
    end
    return 7;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    due_q.delete();
    hist.delete();
    armed    = 1'b0;
    last_e   = 0;
    m_note   = 0;
    m_valid  = 0;
    m_period = 0;
    m_stb    = 0;
  endtask

  task automatic model_step();
    int c, run;
    m_stb = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      if (!armed) begin
        armed  = 1'b1;
        last_e = cyc;
      end else begin
        m_period = cyc - last_e;
        last_e   = cyc;
        m_stb    = 1;
        c        = classify(m_period);
        hist.push_back(c);
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) run++;
        if (c != 7 && run >= SC) begin
          m_note  = c;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
    end else if (armed && (cyc - last_e) == TO) begin
      armed   = 1'b0;
      m_valid = 0;
      hist.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    chk("stb", sample_stb, m_stb);
    chk("period", period, m_period);
    chk("note", note, m_note);
    chk("valid", note_valid, m_valid);
  endtask

  // Drive tone_in to v for n cycles; a qualifying rise is handed to the model.
  task automatic level(logic v, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (v && !prev_lvl && (!FILT || n >= 3)) due_q.push_back(cyc + LAT);
        tone_in  = v;
        prev_lvl = v;
      end
      tick();
    end
  endtask

  task automatic beat_h(int p, int h);
    level(1'b1, h);
    level(1'b0, p - h);
  endtask

  task automatic beat(int p);
    beat_h(p, p / 2);
  endtask

  // One period of tone with a 2-cycle high glitch in the low phase.
  task automatic glitch_beat(int p);
    level(1'b1, p / 2);
    level(1'b0, 200);
    level(1'b1, 2);
    level(1'b0, p - p / 2 - 202);
  endtask

  initial begin
    int k, p, h;
    nom = '{191113 / DIV, 170263 / DIV, 151686 / DIV, 143172 / DIV,
            127553 / DIV, 113636 / DIV, 101238 / DIV};
    rst      = 1'b1;
    tone_in  = 1'b0;
    prev_lvl = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_note", note, 0);
    chk("reset_valid", note_valid, 0);
    chk("reset_period", period, 0);
    chk("reset_stb", sample_stb, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mi stream: first rise arms, second measures, third validates.
    beat(nom[2]);
    beat(nom[2]);
    chk("mi_first_period", period, nom[2]);
    chk("mi_first_valid", note_valid, 0);
    beat(nom[2]);
    chk("mi_note", note, 2);
    chk("mi_valid", note_valid, 1);

    // Period sweep; each rise reports the length of the previous beat.
    beat(nom[0]);
    beat(nom[0]);
    beat(nom[6]);
    chk("do_note", note, 0);
    beat(nom[6]);
    beat(nom[3] + TOL);
    chk("si_note", note, 6);
    beat(nom[3] + TOL);
    beat(nom[3] + TOL + 1);
    chk("fa_edge_note", note, 3);
    chk("fa_edge_valid", note_valid, 1);
    beat(nom[2]);
    chk("oob_period", period, nom[3] + TOL + 1);
    chk("oob_valid", note_valid, 0);
    chk("oob_note_held", note, 3);

    // Mi -> La switch mid-stream.
    beat(nom[2]);
    beat(nom[5]);
    chk("mi_again_note", note, 2);
    beat(nom[5]);
    chk("la_first_valid", note_valid, 0);
    chk("la_first_note", note, 2);
    beat(nom[0]);
    chk("la_note", note, 5);
    chk("la_valid", note_valid, 1);

    // Valid Do, then silence past the timeout.
    beat(nom[0]);
    level(1'b1, nom[0] / 2);
    chk("do_valid_pre_to", note_valid, 1);
    level(1'b0, TO + 50);
    chk("timeout_valid", note_valid, 0);
    chk("timeout_note", note, 0);
    beat(nom[0]);
    beat(nom[0]);
    level(1'b1, nom[0] / 2);
    chk("post_to_valid", note_valid, 1);

    // Asynchronous reset mid-period while valid.
    level(1'b0, 300);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_note", note, 0);
    chk("arst_valid", note_valid, 0);
    chk("arst_period", period, 0);
    chk("arst_stb", sample_stb, 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    level(1'b0, 400);

    // Re tone with 2-cycle glitches.
    beat(nom[1]);
    glitch_beat(nom[1]);
    glitch_beat(nom[1]);
    glitch_beat(nom[1]);
    level(1'b1, nom[1] / 2);
`ifdef NOTE_DET_GLITCH_FILTER_EN
    chk("glitch_period", period, nom[1]);
    chk("glitch_note", note, 1);
    chk("glitch_valid", note_valid, 1);
`else
    chk("glitch_valid", note_valid, 0);
`endif
    level(1'b0, nom[1] - nom[1] / 2);

    // Random periods around each nominal plus out-of-band values.
    for (int i = 0; i < 20; i++) begin
      k = int'($urandom_range(7, 0));
      if (k < 7) p = nom[k] + int'($urandom_range(2 * TOL + 4, 0)) - int'(TOL) - 2;
      else       p = int'($urandom_range(1700, 600));
      h = int'($urandom_range(p - 10, 10));
      beat_h(p, h);
    end
    level(1'b1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
